mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Target side of the CPU byte-wide memory bus: answers every CPU address/data/write cycle.
- Decodes each cycle to one of three targets: internal RAM (addresses below 0x20000), UART I/O (0x30000), or the cycle counter / program-stop port (0x30004–0x30007).
- Buffers outgoing UART bytes in a small FIFO and drives io_buffer_full back to the CPU.
- Sits between the cpu top and the board UART; replaces the bare RAM instance on the CPU side.

Parameters:
- RAM_AW, 17: RAM byte-address width (128 KB).
- TX_DEPTH, 8: tx FIFO depth in bytes; power of two, at least 4.
- FULL_MARGIN, 2: io_buffer_full asserts when free slots ≤ FULL_MARGIN.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- mem_a  in  32  CPU address; only bits 17:0 are decoded
- mem_dout  in  8  CPU write data
- mem_wr  in  1  1 = write, 0 = read
- mem_din  out  8  read data, returned one cycle after the address
- io_buffer_full  out  1  tx FIFO near full
- rx_data  in  8  UART received byte
- rx_valid  in  1  rx_data holds an unread byte
- rx_pop  out  1  1-cycle pulse that consumes rx_data
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- halted  out  1  program-stop seen; sticky until reset

Behaviour:
- Reset (rst_in low, asynchronous):
  - mem_din=0, rx_pop=0, tx_valid=0, halted=0, io_buffer_full=0.
  - FIFO pointers cleared; cycle counter cleared; snapshot register cleared.
  - RAM contents are not cleared.
- Address decode:
  - mem_a[17:16]==2'b11 selects I/O.
  - Otherwise RAM at mem_a[RAM_AW-1:0].
- Every cycle is a transaction; there is no enable.
  - RAM write: takes effect at the clock edge.
  - RAM read: mem_din shows mem[addr] on the next cycle.
  - Write-then-read of the same address on consecutive cycles returns the new value.
- Cycle counter: 32 bits, increments every cycle after reset release, wraps from 0xFFFFFFFF to 0.
- I/O reads (data on mem_din next cycle):
  - 0x30000:
    - rx_valid=1: return rx_data and pulse rx_pop for one cycle in the same cycle.
    - rx_valid=0: return 0x00, no pop.
  - 0x30004: return counter[7:0] and latch the full counter value into the snapshot register.
  - 0x30005, 0x30006, 0x30007: return snapshot bytes 1, 2, 3. The 4-byte little-endian readout is therefore coherent.
  - Any other I/O address: return 0x00.
- I/O writes:
  - 0x30000, nonzero data: push the byte into the tx FIFO.
  - 0x30000, data 0x00: ignored.
  - 0x30004, any data: push 0x00 into the FIFO and set halted.
  - Once halted=1, all later tx pushes are dropped.
  - Any other I/O address: ignored.
- tx FIFO:
  - tx_valid = not empty; tx_data = head byte.
  - Pop on tx_valid && tx_ready.
  - A simultaneous push and pop in the same cycle keeps the count unchanged.
  - Push when full: the byte is dropped and the FIFO is unchanged. The CPU must not let this happen; the bench flags it as an error.
- io_buffer_full is registered: 1 when (TX_DEPTH − count_next) ≤ FULL_MARGIN. This covers one in-flight write after the CPU observes it.
- Reset mid-operation: a pending read result is lost (mem_din=0) and FIFO contents are discarded.

Decomposition:
- Shared package/header (def.v): IO_BASE=0x30000, IO_UART=0x30000, IO_CLK=0x30004, RAM_LIMIT=0x20000, target-select encoding {SEL_RAM, SEL_UART, SEL_CLK, SEL_NONE}.
- One sub-module: tx_byte_fifo (parameterised depth; push/pop/full/empty/count; asynchronous active-low reset).

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 → mem_din=0xA5 on the following cycle; read 0x1FFFF after writing 0x3C there → 0x3C.
- Write 'H' (0x48), 0x00, 'i' (0x69) to 0x30000 with tx_ready=1 → tx emits 0x48 then 0x69 only; halted stays 0.
- Hold tx_ready=0 and write 6 nonzero bytes (TX_DEPTH=8) → io_buffer_full=1 after the 6th push; raise tx_ready for one pop → io_buffer_full returns to 0 the cycle after.
- Run 300 cycles after reset, then read 0x30004..0x30007 on consecutive cycles → the assembled value equals the counter at the 0x30004 read (0x0000012C ± bench offset); bytes 1–3 are unaffected by the counter advancing.
- rx_valid=1 with rx_data=0x5A, read 0x30000 → mem_din=0x5A and rx_pop pulses once; second read with rx_valid=0 → 0x00 and no rx_pop.
- Write any value to 0x30004 → 0x00 pushed to tx and halted=1; a later write of 0x41 to 0x30000 produces no tx; assert rst_in low mid-stream → tx_valid=0 and halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared address map and target-select encoding for the CPU-side memory/IO responder.
// The decode helper maps the 18 decoded address bits to one responder target.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE   = 18'h30000;
  localparam logic [17:0] IO_UART   = 18'h30000;
  localparam logic [17:0] IO_CLK    = 18'h30004;
  localparam logic [17:0] RAM_LIMIT = 18'h20000;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_UART,
    SEL_CLK,
    SEL_NONE
  } tgt_sel_e;

  // 0x30004..0x30007 all land on the counter port; byte lane picked later.
  function automatic tgt_sel_e decode_sel(input logic [17:0] addr);
    if (addr[17:16] != IO_BASE[17:16]) return SEL_RAM;
    if (addr == IO_UART) return SEL_UART;
    if (addr[17:2] == IO_CLK[17:2]) return SEL_CLK;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus: address/data/write from the CPU, read data and tx-near-full back.
// master = CPU side, slave = responder side.
interface mem_io_responder_if;

  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a,
    output mem_dout,
    output mem_wr,
    input  mem_din,
    input  io_buffer_full
  );

  modport slave (
    input  mem_a,
    input  mem_dout,
    input  mem_wr,
    output mem_din,
    output io_buffer_full
  );

endinterface

// File: rtl/mem_io_responder_tx_byte_fifo.sv
// Byte FIFO for outgoing UART data; head visible combinationally, push/pop take effect at the edge.
// Push while full is dropped; pop while empty is ignored; count_next exposes the post-edge occupancy.
module tx_byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_dat,
  input  logic          pop,
  output logic [7:0]    head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next
);

  logic [7:0]  mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign head_dat   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: RAM, UART rx/tx and cycle counter/stop port; read data one cycle later.
// tx bytes queue in a FIFO; io_buffer_full warns the CPU with room left for one in-flight write.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_pop,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                halted
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]        ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_addr;
  logic [17:0]       io_addr;
  tgt_sel_e          sel;
  tgt_sel_e          sel_q;
  logic [7:0]        ram_q;
  logic [7:0]        io_q;
  logic [7:0]        io_rd_dat;
  logic [31:0]       cycle_cnt;
  logic [31:0]       snap;
  logic              full_q;
  logic              is_rd;
  logic              is_wr;
  logic              halt_wr;
  logic              push;
  logic [7:0]        push_dat;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt_next;
  logic [CW-1:0]     unused_fifo_cnt;
  logic              unused_fifo_full;
  logic              unused_hi;

  assign io_addr   = bus.mem_a[17:0];
  assign ram_addr  = bus.mem_a[RAM_AW-1:0];
  assign unused_hi = ^bus.mem_a[31:18];
  assign sel       = decode_sel(io_addr);
  assign is_wr     = bus.mem_wr;
  assign is_rd     = !bus.mem_wr;

  always_ff @(posedge clk_in) begin
    if (is_wr && sel == SEL_RAM) ram[ram_addr] <= bus.mem_dout;
    ram_q <= ram[ram_addr];
  end

  // Counter byte 0 is live; bytes 1..3 come from the snapshot taken on the byte-0 read.
  always_comb begin
    io_rd_dat = 8'h00;
    if (sel == SEL_UART && rx_valid) begin
      io_rd_dat = rx_data;
    end else if (sel == SEL_CLK) begin
      case (io_addr[1:0])
        2'd0:    io_rd_dat = cycle_cnt[7:0];
        2'd1:    io_rd_dat = snap[15:8];
        2'd2:    io_rd_dat = snap[23:16];
        default: io_rd_dat = snap[31:24];
      endcase
    end
  end

  assign rx_pop   = rst_in && is_rd && sel == SEL_UART && rx_valid;
  assign halt_wr  = is_wr && io_addr == IO_CLK;
  assign push     = !halted && (halt_wr || (is_wr && sel == SEL_UART && bus.mem_dout != 8'h00));
  assign push_dat = halt_wr ? 8'h00 : bus.mem_dout;
  assign pop      = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;

  tx_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in     (clk_in),
    .rst_n      (rst_in),
    .push       (push),
    .push_dat   (push_dat),
    .pop        (pop),
    .head_dat   (tx_data),
    .full       (unused_fifo_full),
    .empty      (fifo_empty),
    .count      (unused_fifo_cnt),
    .count_next (fifo_cnt_next)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_q     <= SEL_NONE;
      io_q      <= 8'h00;
      cycle_cnt <= 32'd0;
      snap      <= 32'd0;
      halted    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      sel_q     <= is_wr ? SEL_NONE : sel;
      io_q      <= is_wr ? 8'h00 : io_rd_dat;
      if (is_rd && sel == SEL_CLK && io_addr[1:0] == 2'd0) snap <= cycle_cnt;
      if (halt_wr) halted <= 1'b1;
      full_q    <= (CW'(TX_DEPTH) - fifo_cnt_next) <= CW'(FULL_MARGIN);
    end
  end

  assign bus.mem_din        = (sel_q == SEL_RAM) ? ram_q : io_q;
  assign bus.io_buffer_full = full_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus random bus traffic against a queue/array model.
`timescale 1ns/1ps
module tb_mem_io_responder;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       halted;

  always #5 clk_in = ~clk_in;

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_AW(17), .TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .bus      (bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halted   (halted)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [7:0]  ram_m [int];
  logic [7:0]  txq [$];
  logic [7:0]  emitted [$];
  logic [31:0] cnt_m;
  logic [31:0] snap_m;
  bit          halted_m;
  logic [7:0]  last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive after the edge, check combinational outputs mid-cycle, registered ones after the edge.
  task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic w,
                     input logic rv, input logic [7:0] rd, input logic tr);
    logic [17:0] off;
    bit          io, rd_known, push, was_full;
    logic [7:0]  exp_rd, pdat;
    int          key;
    bus.mem_a = a; bus.mem_dout = d; bus.mem_wr = w;
    rx_valid = rv; rx_data = rd; tx_ready = tr;
    @(negedge clk_in);
    off = a[17:0];
    io  = (off >= 18'h30000);
    key = int'(a[16:0]);
    chk("rx_pop", 32'(rx_pop), 32'(!w && off == 18'h30000 && rv));
    chk("tx_valid", 32'(tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
    if (tx_valid && tx_ready) emitted.push_back(tx_data);
    rd_known = 0; exp_rd = 8'h00; push = 0; pdat = 8'h00;
    if (!w) begin
      if (!io) begin
        if (ram_m.exists(key)) begin rd_known = 1; exp_rd = ram_m[key]; end
      end else begin
        rd_known = 1;
        case (off)
          18'h30000: exp_rd = rv ? rd : 8'h00;
          18'h30004: begin exp_rd = cnt_m[7:0]; snap_m = cnt_m; end
          18'h30005: exp_rd = snap_m[15:8];
          18'h30006: exp_rd = snap_m[23:16];
          18'h30007: exp_rd = snap_m[31:24];
          default:   exp_rd = 8'h00;
        endcase
      end
    end else begin
      if (!io) ram_m[key] = d;
      else if (off == 18'h30000 && d != 8'h00) begin push = !halted_m; pdat = d; end
      else if (off == 18'h30004) begin push = !halted_m; pdat = 8'h00; halted_m = 1; end
    end
    was_full = (txq.size() == DEPTH);
    if (txq.size() != 0 && tr) void'(txq.pop_front());
    if (push) begin
      chk("tx_overflow", 32'(was_full), 32'd0);
      if (!was_full) txq.push_back(pdat);
    end
    @(posedge clk_in); #1;
    cnt_m   = cnt_m + 32'd1;
    last_rd = bus.mem_din;
    if (rd_known) chk("mem_din", 32'(bus.mem_din), 32'(exp_rd));
    chk("io_buffer_full", 32'(bus.io_buffer_full), 32'((DEPTH - txq.size()) <= MARGIN));
    chk("halted", 32'(halted), 32'(halted_m));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_in = 1'b0;
    #3;
    chk("rst_mem_din", 32'(bus.mem_din), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_full", 32'(bus.io_buffer_full), 32'd0);
    chk("rst_rx_pop", 32'(rx_pop), 32'd0);
    txq.delete();
    halted_m = 0; snap_m = 32'd0; cnt_m = 32'd0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
  endtask

  function automatic logic [31:0] ram_addr_rand();
    logic [31:0] a;
    a = $urandom;
    a[16:4] = '0;
    if (a[17:16] == 2'b11) a[17] = 1'b0;
    return a;
  endfunction

  initial begin
    logic [31:0] assembled;
    bus.mem_a = '0; bus.mem_dout = '0; bus.mem_wr = 1'b0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    cnt_m = 0; snap_m = 0; halted_m = 0; last_rd = 0;
    do_reset();

    // RAM write then read, including the top byte of RAM
    cyc(32'h00010, 8'hA5, 1, 0, 8'h00, 0);
    cyc(32'h00010, 8'h00, 0, 0, 8'h00, 0);
    chk("ram_0x10", 32'(last_rd), 32'hA5);
    cyc(32'h1FFFF, 8'h3C, 1, 0, 8'h00, 0);
    cyc(32'h1FFFF, 8'h00, 0, 0, 8'h00, 0);
    chk("ram_0x1ffff", 32'(last_rd), 32'h3C);

    // UART tx: zero byte is swallowed
    emitted.delete();
    cyc(32'h30000, 8'h48, 1, 0, 8'h00, 1);
    cyc(32'h30000, 8'h00, 1, 0, 8'h00, 1);
    cyc(32'h30000, 8'h69, 1, 0, 8'h00, 1);
    repeat (3) cyc(32'h0, 8'h00, 0, 0, 8'h00, 1);
    chk("tx_count", 32'(emitted.size()), 32'd2);
    if (emitted.size() == 2) begin
      chk("tx_byte0", 32'(emitted[0]), 32'h48);
      chk("tx_byte1", 32'(emitted[1]), 32'h69);
    end

    // Near-full threshold
    for (int i = 0; i < 6; i++) cyc(32'h30000, 8'h31 + 8'(i), 1, 0, 8'h00, 0);
    chk("full_after6", 32'(bus.io_buffer_full), 32'd1);
    cyc(32'h0, 8'h00, 0, 0, 8'h00, 1);
    chk("full_after_pop", 32'(bus.io_buffer_full), 32'd0);
    repeat (8) cyc(32'h0, 8'h00, 0, 0, 8'h00, 1);

    // Coherent counter readout 300 cycles after reset
    do_reset();
    repeat (300) cyc(32'h00040, 8'h00, 0, 0, 8'h00, 0);
    cyc(32'h30004, 8'h00, 0, 0, 8'h00, 0); assembled[7:0]   = last_rd;
    cyc(32'h30005, 8'h00, 0, 0, 8'h00, 0); assembled[15:8]  = last_rd;
    cyc(32'h30006, 8'h00, 0, 0, 8'h00, 0); assembled[23:16] = last_rd;
    cyc(32'h30007, 8'h00, 0, 0, 8'h00, 0); assembled[31:24] = last_rd;
    chk("counter_snapshot", assembled, 32'd300);

    // RAM survives reset
    cyc(32'h00010, 8'h00, 0, 0, 8'h00, 0);

    // UART rx
    cyc(32'h30000, 8'h00, 0, 1, 8'h5A, 0);
    chk("rx_read", 32'(last_rd), 32'h5A);
    cyc(32'h30000, 8'h00, 0, 0, 8'hEE, 0);
    chk("rx_empty_read", 32'(last_rd), 32'h00);

    // Random traffic; the CPU side honours io_buffer_full
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [7:0]  d;
      logic        w;
      int          op;
      op = $urandom_range(0, 7);
      d  = 8'($urandom);
      w  = 1'b0;
      a  = ram_addr_rand();
      case (op)
        0, 1: w = 1'b1;
        4: begin
          a = {14'($urandom), 18'h30000};
          w = !bus.io_buffer_full;
          if ($urandom_range(0, 3) == 0) d = 8'h00;
        end
        5: a = {14'($urandom), 18'h30000};
        6: a = {14'($urandom), 18'h30004 + 18'($urandom_range(0, 3))};
        7: begin
          a = {14'($urandom), 18'h30008 + 18'($urandom_range(0, 16'hFFF0))};
          w = 1'($urandom);
        end
        default: ;
      endcase
      cyc(a, d, w, 1'($urandom), 8'($urandom), 1'($urandom));
    end

    // Program stop: 0x00 queued, later tx writes dropped, then reset mid-stream
    repeat (10) cyc(32'h0, 8'h00, 0, 0, 8'h00, 1);
    emitted.delete();
    cyc(32'h30000, 8'h61, 1, 0, 8'h00, 0);
    cyc(32'h30000, 8'h62, 1, 0, 8'h00, 0);
    cyc(32'h30004, 8'h77, 1, 0, 8'h00, 0);
    chk("halt_set", 32'(halted), 32'd1);
    cyc(32'h30000, 8'h41, 1, 0, 8'h00, 0);
    chk("halt_queue_len", 32'(txq.size()), 32'd3);
    cyc(32'h0, 8'h00, 0, 0, 8'h00, 1);
    cyc(32'h0, 8'h00, 0, 0, 8'h00, 1);
    chk("halt_head_zero", 32'(tx_data), 32'h00);
    chk("halt_emit_count", 32'(emitted.size()), 32'd2);
    cyc(32'h00010, 8'h00, 0, 0, 8'h00, 0);
    do_reset();
    cyc(32'h0, 8'h00, 0, 0, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
